k12a_fetch_sequencer: RTL and testbench

Instruction-fetch sequencer directly upstream of the instruction register pair. It owns the program counter, drives the PC onto the address bus, and sequences the two byte fetches (high byte, then low byte). It generates the inst_high_store and inst_low_store strobes, then holds in an execute state until the execute stage signals completion, optionally loading a jump target.

---
 rtl/k12a_fetch_sequencer.sv | 102 ++++++++++
 tb/tb_k12a_fetch_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/k12a_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches the high then low instruction byte,
// and waits in EXEC for the execute stage before fetching again, jumping or halting.
module k12a_fetch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        mem_ready,
   input  logic        exec_done,
   input  logic        jump_en,
   input  logic [15:0] jump_addr,
   input  logic        halt_req,
   input  logic        resume,
   output logic [15:0] addr_out,
   output logic        addr_drive,
   output logic        mem_rd,
   output logic        inst_high_store,
   output logic        inst_low_store,
   output logic        inst_valid,
   output logic        halted,
   output logic [15:0] pc
);

   typedef enum logic [2:0] {
      ST_START    = 3'd0,
      ST_FETCH_HI = 3'd1,
      ST_FETCH_LO = 3'd2,
      ST_EXEC     = 3'd3,
      ST_HALTED   = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc_nxt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_START;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // START exists so that a strobe cannot fire in the cycle reset deasserts.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      addr_out        = 16'h0000;
      addr_drive      = 1'b0;
      mem_rd          = 1'b0;
      inst_high_store = 1'b0;
      inst_low_store  = 1'b0;
      inst_valid      = 1'b0;
      halted          = 1'b0;
      case (state)
         ST_START: begin
            state_nxt = ST_FETCH_HI;
         end
         ST_FETCH_HI: begin
            addr_out   = pc;
            addr_drive = 1'b1;
            mem_rd     = 1'b1;
            if (mem_ready) begin
               inst_high_store = 1'b1;
               pc_nxt          = pc + 16'd1;
               state_nxt       = ST_FETCH_LO;
            end
         end
         ST_FETCH_LO: begin
            addr_out   = pc;
            addr_drive = 1'b1;
            mem_rd     = 1'b1;
            if (mem_ready) begin
               inst_low_store = 1'b1;
               pc_nxt         = pc + 16'd1;
               state_nxt      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            inst_valid = 1'b1;
            if (exec_done) begin
               if (jump_en) begin
                  pc_nxt = jump_addr;
               end
               state_nxt = halt_req ? ST_HALTED : ST_FETCH_HI;
            end
         end
         ST_HALTED: begin
            halted = 1'b1;
            if (resume) begin
               state_nxt = ST_FETCH_HI;
            end
         end
         default: begin
            state_nxt = ST_START;
         end
      endcase
   end

endmodule

// File: tb/tb_k12a_fetch_sequencer.sv
// Scoreboard bench for k12a_fetch_sequencer: directed scenarios followed by random stimulus.
module tb_k12a_fetch_sequencer;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mem_ready, exec_done, jump_en, halt_req, resume;
   logic [15:0] jump_addr;
   logic [15:0] addr_out, pc;
   logic        addr_drive, mem_rd, inst_high_store, inst_low_store, inst_valid, halted;

   k12a_fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
      .clock(clock), .reset_n(reset_n), .mem_ready(mem_ready), .exec_done(exec_done),
      .jump_en(jump_en), .jump_addr(jump_addr), .halt_req(halt_req), .resume(resume),
      .addr_out(addr_out), .addr_drive(addr_drive), .mem_rd(mem_rd),
      .inst_high_store(inst_high_store), .inst_low_store(inst_low_store),
      .inst_valid(inst_valid), .halted(halted), .pc(pc)
   );

   always #5 clock = ~clock;

   // Expected bus view: {addr_out, pc, addr_drive, mem_rd, hi_store, lo_store, valid, halted}
   typedef struct {
      logic [37:0] v;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: the sequencer is a cycle of "phases" over a 16-bit PC.
   localparam int M_START = 0, M_HI = 1, M_LO = 2, M_EXEC = 3, M_HALT = 4;
   int          mdl_mode;
   logic [15:0] mdl_pc;

   task automatic step(input logic rdy, input logic ed, input logic je,
                       input logic [15:0] ja, input logic hr, input logic rs,
                       input string tag);
      exp_t        e;
      logic [15:0] a;
      logic        ad, rd, hs, ls, iv, hl;
      int          nmode;
      logic [15:0] npc;
      mem_ready = rdy; exec_done = ed; jump_en = je; jump_addr = ja;
      halt_req = hr; resume = rs;
      a = 16'h0000; ad = 0; rd = 0; hs = 0; ls = 0; iv = 0; hl = 0;
      if (!reset_n) begin
         mdl_mode = M_START;
         mdl_pc   = RESET_PC;
      end
      nmode = mdl_mode;
      npc   = mdl_pc;
      if (!reset_n) begin
         nmode = M_START;
      end else if (mdl_mode == M_START) begin
         nmode = M_HI;
      end else if (mdl_mode == M_HI || mdl_mode == M_LO) begin
         a = mdl_pc; ad = 1; rd = 1;
         if (rdy) begin
            if (mdl_mode == M_HI) hs = 1; else ls = 1;
            npc   = mdl_pc + 16'd1;
            nmode = mdl_mode + 1;
         end
      end else if (mdl_mode == M_EXEC) begin
         iv = 1;
         if (ed) begin
            if (je) npc = ja;
            nmode = hr ? M_HALT : M_HI;
         end
      end else begin
         hl = 1;
         if (rs) nmode = M_HI;
      end
      e.v   = {a, mdl_pc, ad, rd, hs, ls, iv, hl};
      e.tag = tag;
      sb.push_back(e);
      @(posedge clock);
      #1;
      mdl_mode = nmode;
      mdl_pc   = npc;
   endtask

   task automatic idle(input logic rdy, input string tag);
      step(rdy, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, tag);
   endtask

   always @(negedge clock) begin
      exp_t        e;
      logic [37:0] act;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         act = {addr_out, pc, addr_drive, mem_rd, inst_high_store, inst_low_store,
                inst_valid, halted};
         n_tests++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got addr=%h pc=%h ad,rd,hs,ls,iv,h=%b expected addr=%h pc=%h ad,rd,hs,ls,iv,h=%b",
                     e.tag, act[37:22], act[21:6], act[5:0], e.v[37:22], e.v[21:6], e.v[5:0]);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      mem_ready = 1'b1; exec_done = 0; jump_en = 0; jump_addr = 0; halt_req = 0; resume = 0;
      mdl_mode = M_START;
      mdl_pc   = RESET_PC;
      @(posedge clock);
      #1;

      // Reset held with mem_ready high, then release
      idle(1, "reset_hold");
      idle(1, "reset_hold");
      reset_n = 1'b1;
      idle(1, "start_after_release");
      idle(1, "fetch_hi_0000");
      idle(1, "fetch_lo_0001");
      idle(1, "exec_pc_0002");
      idle(1, "exec_hold_ignores_ready");
      step(1, 1, 0, 16'hBEEF, 0, 0, "exec_done_no_jump");

      // Wait states: 3 in FETCH_HI, 2 in FETCH_LO
      idle(0, "hi_wait1"); idle(0, "hi_wait2"); idle(0, "hi_wait3");
      idle(1, "hi_ready_0002");
      idle(0, "lo_wait1"); idle(0, "lo_wait2");
      idle(1, "lo_ready_0003");
      idle(0, "exec_pc_0004");

      // Jump to 1234
      step(0, 1, 1, 16'h1234, 0, 0, "exec_jump_1234");
      idle(1, "fetch_hi_1234");
      idle(1, "fetch_lo_1235");
      idle(1, "exec_pc_1236");

      // Jump and halt together
      step(1, 1, 1, 16'h0100, 1, 0, "exec_jump_halt");
      for (int i = 0; i < 10; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              16'($urandom), $urandom_range(0, 1), 0, "halted_hold");
      step(1, 0, 0, 16'h0000, 0, 1, "halted_resume");
      idle(1, "fetch_hi_0100");
      idle(1, "fetch_lo_0101");

      // Wrap across FFFF
      step(0, 1, 1, 16'hFFFF, 0, 0, "exec_jump_ffff");
      idle(1, "fetch_hi_ffff");
      idle(1, "fetch_lo_0000");
      idle(0, "exec_pc_0001");
      step(0, 1, 0, 16'h0000, 0, 0, "exec_done_wrap");

      // Reset during a FETCH_LO wait
      idle(1, "fetch_hi_0001");
      idle(0, "lo_wait_before_reset");
      reset_n = 1'b0;
      idle(0, "reset_mid_fetch");
      reset_n = 1'b1;
      idle(1, "start_after_reset");
      idle(1, "fetch_hi_after_reset");

      // Random stimulus with occasional resets
      for (int i = 0; i < 600; i++) begin
         logic [15:0] ja;
         reset_n = ($urandom_range(0, 79) != 0);
         ja = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         step($urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom_range(0, 1), ja,
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0), "random");
      end
      reset_n = 1'b1;
      idle(0, "final");

      @(negedge clock);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
